div_32_iter: RTL and testbench



---
 rtl/div_32_iter_if.sv | 30 +++
 rtl/div_32_iter.sv | 146 ++++++++++++++
 tb/tb_div_32_iter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/div_32_iter_if.sv
`default_nettype none
// ============================================================================
// Module      : div_32_iter_if
// Description : Handshake and operand/result bundle for the iterative divider.
//               The master side issues start/X/Y and receives the results.
//               Optional macro DIV_SIGNED_EN adds the sign_op request bit.
// Revision    : 1.0 - initial release
// ============================================================================
interface div_32_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             busy;
    logic             done;
    logic             div_zero;
`ifdef DIV_SIGNED_EN
    logic             sign_op;

    modport master (output start, X, Y, sign_op, input Q, R, busy, done, div_zero);
    modport slave  (input start, X, Y, sign_op, output Q, R, busy, done, div_zero);
`else
    modport master (output start, X, Y, input Q, R, busy, done, div_zero);
    modport slave  (input start, X, Y, output Q, R, busy, done, div_zero);
`endif
endinterface
`default_nettype wire

// File: rtl/div_32_iter.sv
`default_nettype none
// ============================================================================
// Module      : div_32_iter
// Description : Multi-cycle restoring divider, one quotient bit per clock.
//               start accepted in IDLE, WIDTH RUN steps, one FIX step that
//               writes Q/R/div_zero and pulses done (33 cycles for WIDTH=32).
//               Optional macro DIV_SIGNED_EN adds two's complement division
//               (truncating, remainder takes the dividend's sign).
// Revision    : 1.0 - initial release
// ============================================================================
module div_32_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  wire logic         clk,
    input  wire logic         rst,
    div_32_iter_if.slave      bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvd;        // dividend magnitude, shifted out MSB first
    logic [WIDTH-1:0] dvs;        // divisor magnitude
    logic [WIDTH-1:0] rem;        // partial remainder
    logic [WIDTH-1:0] quo;        // quotient magnitude, shifted in LSB first
    logic             neg_q;
    logic             neg_r;
    logic             dz;

    logic [WIDTH-1:0] q_out;
    logic [WIDTH-1:0] r_out;
    logic             busy_out;
    logic             done_out;
    logic             dz_out;

    logic             neg_x;
    logic             neg_y;
    logic [WIDTH-1:0] mag_x;
    logic [WIDTH-1:0] mag_y;

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign bus.Q        = q_out;
    assign bus.R        = r_out;
    assign bus.busy     = busy_out;
    assign bus.done     = done_out;
    assign bus.div_zero = dz_out;

    // Operand conditioning: take magnitudes of signed operands before latching.
    always_comb begin
`ifdef DIV_SIGNED_EN
        neg_x = bus.sign_op & bus.X[WIDTH-1];
        neg_y = bus.sign_op & bus.Y[WIDTH-1];
`else
        neg_x = 1'b0;
        neg_y = 1'b0;
`endif
        mag_x = neg_x ? ('0 - bus.X) : bus.X;
        mag_y = neg_y ? ('0 - bus.Y) : bus.Y;
    end

    // Trial subtraction. The shifted remainder keeps the old remainder's top
    // bit so divisors above 2^(WIDTH-1) still divide correctly; whenever the
    // trial succeeds the difference is below the divisor, so WIDTH bits hold it.
    always_comb begin
        shifted = {rem, dvd[WIDTH-1]};
        ge      = (shifted >= {1'b0, dvs});
        diff    = shifted[WIDTH-1:0] - dvs;
    end

    // Sign correction; a zero divisor always reports an all-ones quotient,
    // while the remainder naturally equals the original dividend.
    always_comb begin
        q_fix = dz ? '1 : (neg_q ? ('0 - quo) : quo);
        r_fix = neg_r ? ('0 - rem) : rem;
    end

    // Control FSM and datapath; reset aborts any division in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            quo      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
            q_out    <= '0;
            r_out    <= '0;
            busy_out <= 1'b0;
            done_out <= 1'b0;
            dz_out   <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        dvd      <= mag_x;
                        dvs      <= mag_y;
                        rem      <= '0;
                        quo      <= '0;
                        cnt      <= '0;
                        neg_q    <= neg_x ^ neg_y;
                        neg_r    <= neg_x;
                        dz       <= (bus.Y == '0);
                        busy_out <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    dvd <= {dvd[WIDTH-2:0], 1'b0};
                    quo <= {quo[WIDTH-2:0], ge};
                    rem <= ge ? diff : shifted[WIDTH-1:0];
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH-1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    q_out    <= q_fix;
                    r_out    <= r_fix;
                    dz_out   <= dz;
                    done_out <= 1'b1;
                    busy_out <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_32_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_32_iter
// Description : Scoreboard bench for div_32_iter: directed corner cases,
//               handshake/reset scenarios and a randomized regression checked
//               against an arithmetic reference model.
//               Signed cases are exercised when DIV_SIGNED_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_32_iter;

    localparam int LAT   = 33;
    localparam int N_RND = 1500;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic [31:0] dz;
        int          e0;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   errors;
    int   checks;
    exp_t sb[$];

    div_32_iter_if #(.WIDTH(32)) bus ();

    div_32_iter #(.WIDTH(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division; signed overflow and /0 stated directly.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input bit sgn);
        exp_t e;
        e.e0 = 0;
        e.dz = 32'd0;
        if (y == 32'd0) begin
            e.q  = 32'hFFFF_FFFF;
            e.r  = x;
            e.dz = 32'd1;
        end else if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = 32'd0;
        end else if (sgn) begin
            e.q = $signed(x) / $signed(y);
            e.r = $signed(x) % $signed(y);
        end else begin
            e.q = x / y;
            e.r = x % y;
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("Q", bus.Q, e.q);
                check("R", bus.R, e.r);
                check("div_zero", {31'd0, bus.div_zero}, e.dz);
                check("latency", cyc - e.e0, LAT);
            end
        end
    end

    task automatic set_sign(input bit sgn);
`ifdef DIV_SIGNED_EN
        bus.sign_op = sgn;
`else
        if (sgn) $display("signed request ignored in unsigned build");
`endif
    endtask

    // Called on a negedge; waits for IDLE (busy low), then issues one division.
    task automatic do_div(input logic [31:0] x, input logic [31:0] y, input bit sgn);
        exp_t e;
        int   n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy !== 1'b0) begin
            check("idle_timeout", {31'd0, bus.busy}, 32'd0);
        end
        bus.start = 1'b1;
        bus.X     = x;
        bus.Y     = y;
        set_sign(sgn);
        e    = model(x, y, sgn);
        e.e0 = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.X     = 32'd1;
        bus.Y     = 32'd1;
        set_sign(1'b0);
        check("busy_after_start", {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("final_idle", {31'd0, bus.busy}, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ndone;
        int n;
        logic [31:0] x;
        logic [31:0] y;
        exp_t e;

        errors    = 0;
        checks    = 0;
        cyc       = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.X     = 32'd0;
        bus.Y     = 32'd0;
        set_sign(1'b0);

        repeat (3) @(negedge clk);
        check("rst_Q", bus.Q, 32'd0);
        check("rst_R", bus.R, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_div_zero", {31'd0, bus.div_zero}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed corners (issued back-to-back in the done cycle).
        do_div(32'd100, 32'd7, 1'b0);
        do_div(32'h1234_5678, 32'd0, 1'b0);
        do_div(32'hFFFF_FFFF, 32'd16, 1'b0);
        do_div(32'd0, 32'd5, 1'b0);
        do_div(32'hFFFF_FFFF, 32'd1, 1'b0);
        do_div(32'd5, 32'hFFFF_FFFF, 1'b0);
        do_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_div(32'hFFFF_FFF0, 32'h8000_0001, 1'b0);
        do_div(32'd7, 32'd7, 1'b0);
        do_div(32'd0, 32'd0, 1'b0);
`ifdef DIV_SIGNED_EN
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1);
        do_div(32'd7, 32'hFFFF_FFFE, 1'b1);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        do_div(32'hFFFF_FFFB, 32'd0, 1'b1);
        do_div(32'h8000_0000, 32'd0, 1'b1);
        do_div(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1);
        do_div(32'hFFFF_FFF9, 32'd2, 1'b0);
`endif
        wait_idle();

        // start held high: one completion every 34 edges, no queuing.
        bus.start = 1'b1;
        bus.X     = 32'd500;
        bus.Y     = 32'd9;
        e    = model(32'd500, 32'd9, 1'b0);
        for (int k = 0; k < 3; k++) begin
            e.e0 = cyc + 1 + 34 * k;
            sb.push_back(e);
        end
        ndone = 0;
        n     = 0;
        while (ndone < 3 && n < 120) begin
            @(negedge clk);
            n++;
            if (bus.done === 1'b1) begin
                ndone++;
                if (ndone == 3) bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check("held_start_dones", ndone, 32'd3);
        wait_idle();

        // Reset mid-run: aborts immediately, no done for the aborted op.
        bus.start = 1'b1;
        bus.X     = 32'd1000;
        bus.Y     = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_Q", bus.Q, 32'd0);
        check("abort_R", bus.R, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_div(32'd1000, 32'd3, 1'b0);

        // Randomized regression, mixing divisor magnitudes.
        for (int i = 0; i < N_RND; i++) begin
            x = $urandom;
            y = $urandom >> $urandom_range(0, 31);
            if (y == 32'd0) y = 32'd1;
`ifdef DIV_SIGNED_EN
            do_div(x, y, ($urandom_range(0, 1) == 1));
`else
            do_div(x, y, 1'b0);
`endif
        end
        wait_idle();
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
